// File: rtl/unite_controle.sv
// rtl/unite_controle.sv - instruction sequencer for the 16-bit accumulator processing unit
module unite_controle #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  output logic              load_r1,
  output logic              load_accu,
  output logic              load_carry,
  output logic              clear_carry,
  output logic [2:0]        sel_ual,
  input  logic              carry_q,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_LOAD   = 3'd3,
    S_ALU    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_NOR  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_STA  = 3'b011;
  localparam logic [2:0] OP_JCC  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic              unused_ir;

  assign opcode    = ir_q[15:13];
  assign ir_addr   = ir_q[ADDR_W-1:0];
  // Bits between the opcode and the address field carry no meaning.
  assign unused_ir = ^ir_q;

  // Strobes before the ce/reset gate.
  logic raw_en, raw_we, raw_r1, raw_accu, raw_carry, raw_clr;
  logic strobe_ok;

  // State register, program counter and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and PC/IR update; everything holds while ce is low.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (ce) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_NOR, OP_ADD, OP_SUB: state_d = S_LOAD;
            OP_JCC: begin
              if (!carry_q) pc_d = ir_addr;
              state_d = S_FETCH;
            end
            OP_JMP: begin
              pc_d    = ir_addr;
              state_d = S_FETCH;
            end
            OP_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
          endcase
        end
        S_LOAD:  state_d = S_ALU;
        S_ALU:   state_d = S_FETCH;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Moore output decode; strobes are suppressed while ce is low or reset is asserted.
  always_comb begin
    mem_addr  = pc_q;
    raw_en    = 1'b0;
    raw_we    = 1'b0;
    raw_r1    = 1'b0;
    raw_accu  = 1'b0;
    raw_carry = 1'b0;
    raw_clr   = 1'b0;
    sel_ual   = 3'b000;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: raw_en = 1'b1;
      S_EXEC: begin
        mem_addr = ir_addr;
        case (opcode)
          OP_NOR, OP_ADD, OP_SUB: raw_en = 1'b1;
          OP_STA: begin
            raw_en = 1'b1;
            raw_we = 1'b1;
          end
          OP_JCC:  raw_clr = carry_q;
          default: ;
        endcase
      end
      S_LOAD: raw_r1 = 1'b1;
      S_ALU: begin
        case (opcode)
          OP_ADD:  sel_ual = 3'b010;
          OP_SUB:  sel_ual = 3'b011;
          default: sel_ual = 3'b000;
        endcase
        raw_accu  = 1'b1;
        raw_carry = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    strobe_ok   = ce & rst_n;
    mem_en      = raw_en    & strobe_ok;
    mem_we      = raw_we    & strobe_ok;
    load_r1     = raw_r1    & strobe_ok;
    load_accu   = raw_accu  & strobe_ok;
    load_carry  = raw_carry & strobe_ok;
    clear_carry = raw_clr   & strobe_ok;
  end

endmodule

// File: tb/tb_unite_controle.sv
// tb/tb_unite_controle.sv - directed self-checking bench for unite_controle
module tb_unite_controle;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [7:0]  mem_addr;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        load_r1;
  logic        load_accu;
  logic        load_carry;
  logic        clear_carry;
  logic [2:0]  sel_ual;
  logic        carry_q;
  logic        halted;

  int checks;
  int failures;

  unite_controle #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .load_r1(load_r1), .load_accu(load_accu), .load_carry(load_carry),
    .clear_carry(clear_carry), .sel_ual(sel_ual), .carry_q(carry_q), .halted(halted)
  );

  // {mem_en, mem_we, load_r1, load_accu, load_carry, clear_carry, halted, sel_ual}
  logic [9:0] strb;
  assign strb = {mem_en, mem_we, load_r1, load_accu, load_carry, clear_carry, halted, sel_ual};

  localparam logic [9:0] ST_IDLE  = 10'b0000000_000;
  localparam logic [9:0] ST_FETCH = 10'b1000000_000;
  localparam logic [9:0] ST_STA   = 10'b1100000_000;
  localparam logic [9:0] ST_LOAD  = 10'b0010000_000;
  localparam logic [9:0] ST_ADD   = 10'b0001100_010;
  localparam logic [9:0] ST_CLR   = 10'b0000010_000;
  localparam logic [9:0] ST_HALT  = 10'b0000001_000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory and datapath models
  logic [15:0] mem [0:255];
  logic [15:0] r1, accu, ual_out;
  logic        carry_r, ual_co;
  logic        carry_ovr_en, carry_ovr_val;
  int          r1_loads, st_cnt;
  logic [7:0]  st_addr;
  logic [15:0] st_data;

  assign carry_q = carry_ovr_en ? carry_ovr_val : carry_r;

  always_comb begin
    {ual_co, ual_out} = 17'h0;
    case (sel_ual)
      3'b010:  {ual_co, ual_out} = {1'b0, accu} + {1'b0, r1};
      3'b011:  {ual_co, ual_out} = {1'b0, accu} - {1'b0, r1};
      default: {ual_co, ual_out} = {1'b0, ~(accu | r1)};
    endcase
  end

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= '0; accu <= '0; carry_r <= 1'b0;
      r1_loads <= 0; st_cnt <= 0; st_addr <= '0; st_data <= '0;
    end else begin
      if (load_r1) begin
        r1       <= mem_rdata;
        r1_loads <= r1_loads + 1;
      end
      if (load_accu) accu <= ual_out;
      if (clear_carry) carry_r <= 1'b0;
      else if (load_carry) carry_r <= ual_co;
      if (mem_en && mem_we) begin
        st_cnt  <= st_cnt + 1;
        st_addr <= mem_addr;
        st_data <= accu;
      end
    end
  end

  task automatic test_reset();
    mem[0] = 16'h2005;
    mem[5] = 16'h0003;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (strb !== ST_FETCH || mem_addr !== 8'h00) begin failures++;
      $display("FAIL reset_first_fetch strb=%b addr=%h exp %b addr 00", strb, mem_addr, ST_FETCH); end
    repeat (4) @(negedge clk);
    checks++; if (strb !== ST_ADD) begin failures++;
      $display("FAIL reset_reach_alu strb=%b exp %b", strb, ST_ADD); end
    rst_n = 1'b0; #1;
    checks++; if (strb !== ST_IDLE || mem_addr !== 8'h00) begin failures++;
      $display("FAIL reset_mid_alu strb=%b addr=%h exp all zero", strb, mem_addr); end
    @(negedge clk);
    checks++; if (strb !== ST_IDLE) begin failures++;
      $display("FAIL reset_held strb=%b exp %b", strb, ST_IDLE); end
  endtask

  task automatic test_add();
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (strb !== ST_FETCH || mem_addr !== 8'h00) begin failures++;
      $display("FAIL add_fetch strb=%b addr=%h exp %b addr 00", strb, mem_addr, ST_FETCH); end
    @(negedge clk);
    checks++; if (strb !== ST_IDLE) begin failures++;
      $display("FAIL add_decode strb=%b exp %b", strb, ST_IDLE); end
    @(negedge clk);
    checks++; if (strb !== ST_FETCH || mem_addr !== 8'h05) begin failures++;
      $display("FAIL add_exec strb=%b addr=%h exp %b addr 05", strb, mem_addr, ST_FETCH); end
    @(negedge clk);
    checks++; if (strb !== ST_LOAD) begin failures++;
      $display("FAIL add_load strb=%b exp %b", strb, ST_LOAD); end
    @(negedge clk);
    checks++; if (strb !== ST_ADD) begin failures++;
      $display("FAIL add_alu strb=%b exp %b", strb, ST_ADD); end
    @(negedge clk);
    checks++; if (strb !== ST_FETCH || mem_addr !== 8'h01 || accu !== 16'h0003) begin failures++;
      $display("FAIL add_next_fetch strb=%b addr=%h accu=%h exp addr 01 accu 0003", strb, mem_addr, accu); end
  endtask

  task automatic test_sta();
    mem[1] = 16'h6010;
    @(negedge clk);
    @(negedge clk);
    checks++; if (strb !== ST_STA || mem_addr !== 8'h10) begin failures++;
      $display("FAIL sta_exec strb=%b addr=%h exp %b addr 10", strb, mem_addr, ST_STA); end
    @(negedge clk);
    checks++; if (strb !== ST_FETCH || mem_addr !== 8'h02) begin failures++;
      $display("FAIL sta_next_fetch strb=%b addr=%h exp addr 02", strb, mem_addr); end
    checks++; if (st_cnt !== 1 || st_addr !== 8'h10 || st_data !== 16'h0003) begin failures++;
      $display("FAIL sta_store cnt=%0d addr=%h data=%h exp 1 10 0003", st_cnt, st_addr, st_data); end
  endtask

  task automatic test_jcc();
    mem[2]     = 16'h8020;
    mem[8'h20] = 16'h8020;
    carry_ovr_en = 1'b1; carry_ovr_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (strb !== ST_IDLE) begin failures++;
      $display("FAIL jcc_taken_exec strb=%b exp %b", strb, ST_IDLE); end
    @(negedge clk);
    checks++; if (strb !== ST_FETCH || mem_addr !== 8'h20) begin failures++;
      $display("FAIL jcc_taken_fetch strb=%b addr=%h exp addr 20", strb, mem_addr); end
    carry_ovr_val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (strb !== ST_CLR) begin failures++;
      $display("FAIL jcc_not_taken_clear strb=%b exp %b", strb, ST_CLR); end
    @(negedge clk);
    checks++; if (strb !== ST_FETCH || mem_addr !== 8'h21) begin failures++;
      $display("FAIL jcc_not_taken_fetch strb=%b addr=%h exp addr 21", strb, mem_addr); end
    carry_ovr_en = 1'b0;
  endtask

  task automatic test_wrap_halt();
    int bad;
    mem[8'h21] = 16'hA0FF;
    mem[8'hFF] = 16'hE000;
    repeat (3) @(negedge clk);
    checks++; if (strb !== ST_FETCH || mem_addr !== 8'hFF) begin failures++;
      $display("FAIL jmp_fetch strb=%b addr=%h exp addr ff", strb, mem_addr); end
    repeat (2) @(negedge clk);
    checks++; if (strb !== ST_IDLE) begin failures++;
      $display("FAIL nop_exec strb=%b exp %b", strb, ST_IDLE); end
    @(negedge clk);
    checks++; if (strb !== ST_FETCH || mem_addr !== 8'h00) begin failures++;
      $display("FAIL wrap_fetch strb=%b addr=%h exp addr 00", strb, mem_addr); end
    mem[0] = 16'hC000;
    repeat (2) @(negedge clk);
    checks++; if (strb !== ST_IDLE) begin failures++;
      $display("FAIL halt_exec strb=%b exp %b", strb, ST_IDLE); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (strb !== ST_HALT) bad++;
    end
    checks++; if (bad != 0) begin failures++;
      $display("FAIL halt_hold bad_cycles=%0d exp 0 last strb=%b", bad, strb); end
  endtask

  task automatic test_ce_stall();
    rst_n = 1'b0;
    @(negedge clk);
    mem[0] = 16'h2005;
    mem[5] = 16'h0003;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (strb !== ST_LOAD) begin failures++;
      $display("FAIL stall_reach_load strb=%b exp %b", strb, ST_LOAD); end
    ce = 1'b0; #1;
    checks++; if (strb !== ST_IDLE) begin failures++;
      $display("FAIL stall_gate strb=%b exp %b", strb, ST_IDLE); end
    repeat (2) @(negedge clk);
    checks++; if (strb !== ST_IDLE || r1_loads !== 0) begin failures++;
      $display("FAIL stall_hold strb=%b r1_loads=%0d exp 0", strb, r1_loads); end
    @(negedge clk);
    ce = 1'b1; #1;
    checks++; if (strb !== ST_LOAD) begin failures++;
      $display("FAIL stall_resume strb=%b exp %b", strb, ST_LOAD); end
    @(negedge clk);
    checks++; if (strb !== ST_ADD || r1_loads !== 1) begin failures++;
      $display("FAIL stall_alu strb=%b r1_loads=%0d exp 1", strb, r1_loads); end
    @(negedge clk);
    checks++; if (strb !== ST_FETCH || mem_addr !== 8'h01 || accu !== 16'h0003) begin failures++;
      $display("FAIL stall_result strb=%b addr=%h accu=%h exp addr 01 accu 0003", strb, mem_addr, accu); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    ce = 1'b1;
    carry_ovr_en = 1'b0;
    carry_ovr_val = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    test_reset();
    test_add();
    test_sta();
    test_jcc();
    test_wrap_halt();
    test_ce_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
